// File: rtl/trigger_time_reader.sv
// Host-side master for the triggerer serial shift-out port: raises DAT_ENA, toggles DAT_CLK and samples DAT_OUT MSB-first.
// Latency: 1 + 2*ENA_SETUP + 2*CLK_DIV*WORD_WIDTH clk per word; start is ignored while busy (no queueing).
module trigger_time_reader #(
  parameter int WORD_WIDTH  = 24,
  parameter int CLK_DIV     = 6,
  parameter int ENA_SETUP   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid,
  output logic                  dat_ena,
  output logic                  dat_clk,
  input  logic                  dat_in
);

  localparam int HP_MAX = (CLK_DIV > ENA_SETUP) ? CLK_DIV : ENA_SETUP;
  localparam int HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int BIT_W  = $clog2(WORD_WIDTH + 1);

  localparam logic [HP_W-1:0]  HP_SETUP = HP_W'(ENA_SETUP - 1);
  localparam logic [HP_W-1:0]  HP_DIV   = HP_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [HP_W-1:0]       r_hp_cnt;
  logic [HP_W-1:0]       w_hp_cnt_nxt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BIT_W-1:0]      w_bit_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] w_shift_nxt;
  logic [WORD_WIDTH-1:0] r_word;
  logic [WORD_WIDTH-1:0] w_word_nxt;
  logic                  w_word_valid_nxt;
  logic                  r_word_valid;
  logic                  r_busy;
  logic                  r_dat_ena;
  logic                  r_dat_clk;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  w_dat_sync;
  logic                  w_hp_done;

  assign w_dat_sync = r_sync[SYNC_STAGES-1];
  assign w_hp_done  = (r_hp_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], dat_in};
    end
  end

  // Every phase lasts (reload value + 1) cycles; the counter is reloaded on each state entry.
  always_comb begin
    w_state_nxt      = r_state;
    w_hp_cnt_nxt     = w_hp_done ? r_hp_cnt : (r_hp_cnt - HP_W'(1));
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_word_nxt       = r_word;
    w_word_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_SETUP;
          w_hp_cnt_nxt  = HP_SETUP;
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (w_hp_done) begin
          w_state_nxt  = S_LOW;
          w_hp_cnt_nxt = HP_DIV;
        end
      end
      S_LOW: begin
        if (w_hp_done) begin
          w_state_nxt   = S_HIGH;
          w_hp_cnt_nxt  = HP_DIV;
          w_shift_nxt   = {r_shift[WORD_WIDTH-2:0], w_dat_sync};
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
        end
      end
      S_HIGH: begin
        if (w_hp_done) begin
          if (r_bit_cnt < BIT_LAST) begin
            w_state_nxt  = S_LOW;
            w_hp_cnt_nxt = HP_DIV;
          end else begin
            w_state_nxt      = S_GAP;
            w_hp_cnt_nxt     = HP_SETUP;
            w_word_nxt       = r_shift;
            w_word_valid_nxt = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_hp_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pin-level outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hp_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_dat_ena    <= 1'b0;
      r_dat_clk    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hp_cnt     <= w_hp_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_dat_ena    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_LOW) ||
                      (w_state_nxt == S_HIGH);
      r_dat_clk    <= (w_state_nxt == S_HIGH);
    end
  end

  assign busy       = r_busy;
  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign dat_ena    = r_dat_ena;
  assign dat_clk    = r_dat_clk;

endmodule

// File: tb/tb_trigger_time_reader.sv
// Bench for trigger_time_reader: behavioural shift-out target, expected-word queue, pin protocol monitor.
module tb_trigger_time_reader;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         dat_in;
  logic         busy, word_valid, dat_ena, dat_clk;
  logic [W-1:0] word;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  trigger_time_reader #(
    .WORD_WIDTH(W), .CLK_DIV(6), .ENA_SETUP(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .word(word),
    .word_valid(word_valid), .dat_ena(dat_ena), .dat_clk(dat_clk), .dat_in(dat_in)
  );

  // Target: loads on DAT_ENA rise, shifts on DAT_CLK fall while enabled.
  logic [W-1:0] tgt_word = '0;
  logic [W-1:0] tgt_sr = '0;
  logic         tgt_ena_q = 1'b0;
  logic         tgt_clk_q = 1'b0;
  logic         tgt_delay = 1'b0;
  logic [2:0]   tgt_pipe = '0;

  always @(dat_ena or dat_clk) begin
    if (dat_ena === 1'b1 && !tgt_ena_q) tgt_sr = tgt_word;
    else if (dat_ena === 1'b1 && tgt_clk_q && dat_clk === 1'b0) tgt_sr = {tgt_sr[W-2:0], 1'b0};
    tgt_ena_q = (dat_ena === 1'b1);
    tgt_clk_q = (dat_clk === 1'b1);
  end

  // Slow target: DAT_OUT becomes visible in the fourth clk cycle after each update.
  always @(posedge clk) tgt_pipe <= {tgt_pipe[1:0], tgt_sr[W-1]};
  assign dat_in = tgt_delay ? tgt_pipe[2] : tgt_sr[W-1];

  // Pin monitor, sampled mid-cycle.
  int mon_cyc = 0, mon_rises = 0, mon_wv = 0, mon_noena = 0;
  int mon_period_err = 0, mon_duty_err = 0, mon_ena_lead = -1, mon_ena_low = -1;
  int last_rise = 0, ena_rise_at = 0, ena_fall_at = 0;
  bit have_rise = 0, seen_fall = 0, prev_clk = 0, prev_ena = 0;

  always @(negedge clk) begin
    mon_cyc++;
    if (dat_clk !== prev_clk && !prev_ena) mon_noena++;
    if (dat_ena === 1'b1 && !prev_ena) begin
      ena_rise_at = mon_cyc;
      if (seen_fall) mon_ena_low = mon_cyc - ena_fall_at;
      have_rise = 0;
    end
    if (dat_ena === 1'b0 && prev_ena) begin
      ena_fall_at = mon_cyc;
      seen_fall = 1;
    end
    if (dat_clk === 1'b1 && !prev_clk) begin
      mon_rises++;
      if (have_rise) begin
        if (mon_cyc - last_rise != 12) mon_period_err++;
      end else begin
        mon_ena_lead = mon_cyc - ena_rise_at;
      end
      have_rise = 1;
      last_rise = mon_cyc;
    end
    if (dat_clk === 1'b0 && prev_clk && (mon_cyc - last_rise != 6)) mon_duty_err++;
    if (word_valid === 1'b1) mon_wv++;
    prev_clk = (dat_clk === 1'b1);
    prev_ena = (dat_ena === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] w, input bit expect_word);
    tgt_word = w;
    if (expect_word) exp_q.push_back(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_word(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (word_valid === 1'b1) got = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dat_ena !== 1'b0) begin errors++; $display("FAIL reset_dat_ena: got %b want 0", dat_ena); end
    checks++; if (dat_clk !== 1'b0) begin errors++; $display("FAIL reset_dat_clk: got %b want 0", dat_clk); end
    checks++; if (word !== '0) begin errors++; $display("FAIL reset_word: got %h want 000000", word); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || dat_ena !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b dat_ena %b want 0 0", busy, dat_ena); end
  endtask

  task automatic test_single();
    int wv_k, wv_n, idle_k, busy_hi;
    logic [W-1:0] e;
    wv_k = -1; wv_n = 0; idle_k = -1; busy_hi = 0;
    exp_q.delete();
    pulse_start(24'hA5C30F, 1);
    checks++; if (busy !== 1'b1 || dat_ena !== 1'b1 || dat_clk !== 1'b0) begin errors++; $display("FAIL single_first_cycle: busy/ena/clk %b%b%b want 110", busy, dat_ena, dat_clk); end
    for (int k = 1; k <= 310; k++) begin
      tick();
      if (word_valid === 1'b1) begin
        wv_n++;
        if (wv_k < 0) wv_k = k;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_word: unexpected word %h", word); end
        else begin e = exp_q.pop_front(); if (word !== e) begin errors++; $display("FAIL single_word: got %h want %h", word, e); end end
      end
      if (idle_k < 0 && busy === 1'b1) busy_hi++;
      if (idle_k < 0 && busy === 1'b0) idle_k = k;
    end
    checks++; if (wv_n != 1) begin errors++; $display("FAIL single_wv_count: got %0d want 1", wv_n); end
    checks++; if (wv_k != 292) begin errors++; $display("FAIL single_wv_cycle: got edge %0d want 292", wv_k); end
    checks++; if (idle_k != 296) begin errors++; $display("FAIL single_busy_fall: got edge %0d want 296", idle_k); end
    checks++; if (busy_hi != 295) begin errors++; $display("FAIL single_busy_len: got %0d want 295", busy_hi); end
    checks++; if (word !== 24'hA5C30F) begin errors++; $display("FAIL single_word_hold: got %h want a5c30f", word); end
  endtask

  task automatic test_protocol();
    int r0, p0, d0, n0;
    bit got;
    logic [W-1:0] e;
    exp_q.delete();
    r0 = mon_rises; p0 = mon_period_err; d0 = mon_duty_err; n0 = mon_noena;
    pulse_start(24'h3C3C3C, 1);
    wait_word(400, got);
    checks++;
    if (!got) begin errors++; $display("FAIL protocol_word: no word_valid within 400 cycles"); end
    else begin e = exp_q.pop_front(); if (word !== e) begin errors++; $display("FAIL protocol_word: got %h want %h", word, e); end end
    repeat (10) tick();
    checks++; if (mon_rises - r0 != 24) begin errors++; $display("FAIL protocol_rises: got %0d want 24", mon_rises - r0); end
    checks++; if (mon_period_err != p0) begin errors++; $display("FAIL protocol_period: %0d periods not 12 cycles, want 0", mon_period_err - p0); end
    checks++; if (mon_duty_err != d0) begin errors++; $display("FAIL protocol_duty: %0d high phases not 6 cycles, want 0", mon_duty_err - d0); end
    checks++; if (mon_noena != n0) begin errors++; $display("FAIL protocol_clk_no_ena: %0d edges, want 0", mon_noena - n0); end
    checks++; if (mon_ena_lead != 10) begin errors++; $display("FAIL protocol_ena_lead: got %0d want 10", mon_ena_lead); end
  endtask

  task automatic test_back_to_back();
    int n, k;
    int wv_at[2];
    logic [W-1:0] e;
    exp_q.delete();
    n = 0; k = 0;
    wv_at[0] = 0; wv_at[1] = 0;
    tgt_word = 24'h000001;
    exp_q.push_back(24'h000001);
    exp_q.push_back(24'hFFFFFE);
    start = 1'b1;
    while (n < 2 && k < 800) begin
      tick();
      k++;
      if (word_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_word: unexpected word %h", word); end
        else begin e = exp_q.pop_front(); if (word !== e) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", n, word, e); end end
        wv_at[n] = k;
        n++;
        tgt_word = 24'hFFFFFE;
      end
    end
    start = 1'b0;
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_count: got %0d words in 800 cycles want 2", n); end
    checks++; if (wv_at[1] - wv_at[0] != 297) begin errors++; $display("FAIL b2b_spacing: got %0d want 297", wv_at[1] - wv_at[0]); end
    checks++; if (mon_ena_low < 4) begin errors++; $display("FAIL b2b_ena_low: got %0d want >= 4", mon_ena_low); end
    repeat (10) tick();
  endtask

  task automatic test_ignored_start();
    int r0, w0;
    logic [W-1:0] e;
    exp_q.delete();
    r0 = mon_rises; w0 = mon_wv;
    pulse_start(24'h5A5A5A, 1);
    for (int k = 1; k <= 320; k++) begin
      start = (k == 10 || k == 100);
      tick();
      start = 1'b0;
      if (word_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ignore_word: unexpected word %h", word); end
        else begin e = exp_q.pop_front(); if (word !== e) begin errors++; $display("FAIL ignore_word: got %h want %h", word, e); end end
      end
    end
    repeat (2) tick();
    checks++; if (mon_wv - w0 != 1) begin errors++; $display("FAIL ignore_wv_count: got %0d want 1", mon_wv - w0); end
    checks++; if (mon_rises - r0 != 24) begin errors++; $display("FAIL ignore_rises: got %0d want 24", mon_rises - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit got;
    logic [W-1:0] e;
    exp_q.delete();
    w0 = mon_wv;
    pulse_start(24'h777777, 0);
    for (int k = 1; k <= 150; k++) begin
      rst = (k == 150);
      tick();
    end
    rst = 1'b0;
    checks++; if (dat_ena !== 1'b0) begin errors++; $display("FAIL midrst_dat_ena: got %b want 0", dat_ena); end
    checks++; if (dat_clk !== 1'b0) begin errors++; $display("FAIL midrst_dat_clk: got %b want 0", dat_clk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (word !== '0) begin errors++; $display("FAIL midrst_word: got %h want 000000", word); end
    repeat (20) tick();
    checks++; if (mon_wv != w0) begin errors++; $display("FAIL midrst_no_wv: got %0d pulses want 0", mon_wv - w0); end
    pulse_start(24'h123456, 1);
    wait_word(400, got);
    checks++;
    if (!got) begin errors++; $display("FAIL midrst_reread: no word_valid within 400 cycles"); end
    else begin e = exp_q.pop_front(); if (word !== e) begin errors++; $display("FAIL midrst_reread: got %h want %h", word, e); end end
    repeat (10) tick();
  endtask

  task automatic test_delayed_target();
    bit got;
    logic [W-1:0] e;
    exp_q.delete();
    tgt_delay = 1'b1;
    repeat (5) tick();
    pulse_start(24'h800001, 1);
    wait_word(400, got);
    checks++;
    if (!got) begin errors++; $display("FAIL delayed_word: no word_valid within 400 cycles"); end
    else begin e = exp_q.pop_front(); if (word !== e) begin errors++; $display("FAIL delayed_word: got %h want %h", word, e); end end
    repeat (10) tick();
    tgt_delay = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_protocol();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_delayed_target();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
